// File: rtl/spi_mstr_gen.sv
// Parametrised SPI master: 1..MAX_W-bit frames, all CPOL/CPHA modes, MSB/LSB first,
// programmable SCLK divider, MISO capture and SS_n-held bursts.
module spi_mstr_gen #(
    parameter int MAX_W = 32,
    parameter int DIV_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wrt,
    input  logic [MAX_W-1:0]           data_out,
    input  logic [$clog2(MAX_W)-1:0]   len,
    input  logic                       cpol,
    input  logic                       cpha,
    input  logic                       lsb_first,
    input  logic [DIV_W-1:0]           div,
    input  logic                       hold_ss,
    input  logic                       ss_rel,
    input  logic                       MISO,
    output logic                       SS_n,
    output logic                       SCLK,
    output logic                       MOSI,
    output logic                       busy,
    output logic                       done,
    output logic [MAX_W-1:0]           data_in
);
    localparam int LW = $clog2(MAX_W);
    localparam int EW = LW + 2;
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, BACK, HOLD} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic [MAX_W-1:0]  tx_q, tx_d, rx_q, rx_d, data_in_q, data_in_d;
    logic [LW-1:0]     rx_idx_q, rx_idx_d, len_q, len_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, hold_q, hold_d;
    logic              ss_n_q, ss_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic [LW-1:0]     len_clamp_s;
    logic [MAX_W-1:0]  tx_load_s, tx_next_s;
    logic [EW-1:0]     edge_nxt_s, two_n_s;

    function automatic logic tx_head(input logic [MAX_W-1:0] v, input logic lsb);
        if (lsb) begin
            tx_head = v[0];
        end else begin
            tx_head = v[MAX_W-1];
        end
    endfunction

    function automatic logic [MAX_W-1:0] tx_shift(input logic [MAX_W-1:0] v, input logic lsb);
        if (lsb) begin
            tx_shift = v >> 1;
        end else begin
            tx_shift = v << 1;
        end
    endfunction

    // Non-power-of-2 widths can encode lengths beyond the last bit; clamp them.
    if ((1 << LW) == MAX_W) begin : g_len_pow2
        assign len_clamp_s = len;
    end else begin : g_len_clamp
        assign len_clamp_s = (len > LEN_MAX) ? LEN_MAX : len;
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;  div_d = div_q;  edge_d = edge_q;
        tx_d = tx_q;  rx_d = rx_q;  rx_idx_d = rx_idx_q;  len_d = len_q;
        cpol_d = cpol_q;  cpha_d = cpha_q;  lsb_d = lsb_q;  hold_d = hold_q;
        ss_n_d = ss_n_q;  sclk_d = sclk_q;  mosi_d = mosi_q;
        busy_d = busy_q;  done_d = 1'b0;  data_in_d = data_in_q;

        // MSB-first frames are pre-aligned so the first bit sits at the top.
        if (lsb_first) begin
            tx_load_s = data_out;
        end else begin
            tx_load_s = data_out << (LEN_MAX - len_clamp_s);
        end
        tx_next_s  = tx_shift(tx_q, lsb_q);
        edge_nxt_s = edge_q + EW'(1);
        two_n_s    = (EW'(len_q) + EW'(1)) << 1;

        if (((state_q == IDLE) || (state_q == HOLD)) && wrt) begin
            state_d  = SETUP;
            cnt_d    = '0;
            edge_d   = '0;
            div_d    = div;
            len_d    = len_clamp_s;
            cpol_d   = cpol;
            cpha_d   = cpha;
            lsb_d    = lsb_first;
            hold_d   = hold_ss;
            tx_d     = tx_load_s;
            rx_d     = '0;
            rx_idx_d = '0;
            ss_n_d   = 1'b0;
            busy_d   = 1'b1;
            sclk_d   = cpol;
            mosi_d   = cpha ? 1'b0 : tx_head(tx_load_s, lsb_first);
        end else begin
            case (state_q)
                IDLE: begin
                    sclk_d = cpol;
                    ss_n_d = 1'b1;
                    mosi_d = 1'b0;
                    busy_d = 1'b0;
                end
                HOLD: begin
                    if (ss_rel) begin
                        state_d = IDLE;
                        ss_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                    end else begin
                        sclk_d = cpol_q;
                    end
                end
                SETUP, XFER: begin
                    if (cnt_q == div_q) begin
                        cnt_d   = '0;
                        sclk_d  = ~sclk_q;
                        edge_d  = edge_nxt_s;
                        state_d = (edge_nxt_s == two_n_s) ? BACK : XFER;
                        // Odd edges are leading; the phase decides launch vs capture.
                        if (edge_nxt_s[0] != cpha_q) begin
                            if (lsb_q) begin
                                rx_d[rx_idx_q] = MISO;
                                rx_idx_d       = rx_idx_q + LW'(1);
                            end else begin
                                rx_d = {rx_q[MAX_W-2:0], MISO};
                            end
                        end else if (cpha_q) begin
                            mosi_d = tx_head(tx_q, lsb_q);
                            tx_d   = tx_next_s;
                        end else if (edge_nxt_s != two_n_s) begin
                            mosi_d = tx_head(tx_next_s, lsb_q);
                            tx_d   = tx_next_s;
                        end else begin
                            mosi_d = mosi_q;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                BACK: begin
                    if (cnt_q == div_q) begin
                        cnt_d     = '0;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        data_in_d = rx_q;
                        if (hold_q) begin
                            state_d = HOLD;
                        end else begin
                            state_d = IDLE;
                            ss_n_d  = 1'b1;
                            mosi_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    ss_n_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;  cnt_q <= '0;  div_q <= '0;  edge_q <= '0;
            tx_q <= '0;  rx_q <= '0;  rx_idx_q <= '0;  len_q <= '0;
            cpol_q <= 1'b0;  cpha_q <= 1'b0;  lsb_q <= 1'b0;  hold_q <= 1'b0;
            ss_n_q <= 1'b1;  sclk_q <= 1'b0;  mosi_q <= 1'b0;
            busy_q <= 1'b0;  done_q <= 1'b0;  data_in_q <= '0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;  div_q <= div_d;  edge_q <= edge_d;
            tx_q <= tx_d;  rx_q <= rx_d;  rx_idx_q <= rx_idx_d;  len_q <= len_d;
            cpol_q <= cpol_d;  cpha_q <= cpha_d;  lsb_q <= lsb_d;  hold_q <= hold_d;
            ss_n_q <= ss_n_d;  sclk_q <= sclk_d;  mosi_q <= mosi_d;
            busy_q <= busy_d;  done_q <= done_d;  data_in_q <= data_in_d;
        end
    end

    assign SS_n    = ss_n_q;
    assign SCLK    = sclk_q;
    assign MOSI    = mosi_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign data_in = data_in_q;
endmodule

// File: tb/tb_spi_mstr_gen.sv
// Directed self-checking bench for spi_mstr_gen with MISO looped back to MOSI.
module tb_spi_mstr_gen;
    logic        clk = 1'b0;
    logic        rst, wrt, cpol, cpha, lsb_first, hold_ss, ss_rel;
    logic [31:0] data_out;
    logic [4:0]  len;
    logic [7:0]  div;
    logic        SS_n, SCLK, MOSI, busy, done;
    logic [31:0] data_in;

    int checks = 0;
    int failures = 0;
    int done_cyc, n_edges, first_edge, last_edge, ss_high, busy_cnt, lead_cnt;
    int again_cyc = -1;
    logic [31:0] mosi_vec, din_at_done;
    logic        ss_at_done, busy_at_done;

    always #5 clk = ~clk;

    spi_mstr_gen #(.MAX_W(32), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .wrt(wrt), .data_out(data_out), .len(len),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .div(div),
        .hold_ss(hold_ss), .ss_rel(ss_rel), .MISO(MOSI),
        .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .busy(busy), .done(done),
        .data_in(data_in)
    );

    // Called at the negedge of cycle 0 with wrt already high; records the frame until done.
    task automatic watch(input int limit);
        logic prev;
        done_cyc = -1; n_edges = 0; first_edge = -1; last_edge = -1;
        ss_high = 0; busy_cnt = 0; lead_cnt = 0; mosi_vec = '0;
        prev = SCLK;
        @(posedge clk); #1;
        wrt = 1'b0; ss_rel = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            wrt = (c == again_cyc) ? 1'b1 : 1'b0;
            if (SCLK !== prev) begin
                n_edges++;
                if (first_edge < 0) first_edge = c;
                last_edge = c;
                if (SCLK !== cpol && lead_cnt < 32) begin
                    mosi_vec[lead_cnt] = MOSI;
                    lead_cnt++;
                end
                prev = SCLK;
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cyc = c; ss_at_done = SS_n; busy_at_done = busy; din_at_done = data_in;
                break;
            end
            if (SS_n !== 1'b0) ss_high++;
        end
        wrt = 1'b0;
        if (done_cyc < 0) begin
            checks++; failures++;
            $display("FAIL watch_timeout no done within %0d cycles", limit);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (SS_n !== 1'b1) begin failures++; $display("FAIL rst_ss_n got=%b exp=1", SS_n); end
        checks++; if (SCLK !== 1'b0) begin failures++; $display("FAIL rst_sclk got=%b exp=0", SCLK); end
        checks++; if (MOSI !== 1'b0) begin failures++; $display("FAIL rst_mosi got=%b exp=0", MOSI); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (data_in !== 32'h0) begin failures++; $display("FAIL rst_data_in got=%h exp=0", data_in); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0_msb;
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; len = 5'd7; div = 8'd1;
        data_out = 32'hA5; hold_ss = 1'b0;
        @(negedge clk); wrt = 1'b1;
        watch(200);
        checks++; if (done_cyc != 35) begin failures++; $display("FAIL m0_done_cyc got=%0d exp=35", done_cyc); end
        checks++; if (n_edges != 16) begin failures++; $display("FAIL m0_edges got=%0d exp=16", n_edges); end
        checks++; if (first_edge != 3) begin failures++; $display("FAIL m0_first_edge got=%0d exp=3", first_edge); end
        checks++; if (last_edge != 33) begin failures++; $display("FAIL m0_last_edge got=%0d exp=33", last_edge); end
        checks++; if (busy_cnt != 34) begin failures++; $display("FAIL m0_busy_cycles got=%0d exp=34", busy_cnt); end
        checks++; if (ss_high != 0) begin failures++; $display("FAIL m0_ss_high got=%0d exp=0", ss_high); end
        checks++; if (ss_at_done !== 1'b1) begin failures++; $display("FAIL m0_ss_at_done got=%b exp=1", ss_at_done); end
        checks++; if (din_at_done !== 32'hA5) begin failures++; $display("FAIL m0_data_in got=%h exp=000000a5", din_at_done); end
        checks++; if (mosi_vec[7:0] !== 8'hA5) begin failures++; $display("FAIL m0_mosi_seq got=%h exp=a5", mosi_vec[7:0]); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL m0_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_mode3_lsb;
        cpol = 1'b1; cpha = 1'b1; lsb_first = 1'b1; len = 5'd15; div = 8'd0;
        data_out = 32'h1234; hold_ss = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (SCLK !== 1'b1) begin failures++; $display("FAIL m3_idle_sclk got=%b exp=1", SCLK); end
        wrt = 1'b1;
        watch(200);
        checks++; if (done_cyc != 34) begin failures++; $display("FAIL m3_done_cyc got=%0d exp=34", done_cyc); end
        checks++; if (n_edges != 32) begin failures++; $display("FAIL m3_edges got=%0d exp=32", n_edges); end
        checks++; if (first_edge != 2) begin failures++; $display("FAIL m3_first_edge got=%0d exp=2", first_edge); end
        checks++; if (din_at_done !== 32'h1234) begin failures++; $display("FAIL m3_data_in got=%h exp=00001234", din_at_done); end
        checks++; if (mosi_vec[15:0] !== 16'h1234) begin failures++; $display("FAIL m3_mosi_seq got=%h exp=1234", mosi_vec[15:0]); end
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_burst;
        len = 5'd7; div = 8'd1; hold_ss = 1'b1; data_out = 32'h3C;
        @(negedge clk); wrt = 1'b1;
        watch(200);
        checks++; if (done_cyc != 35) begin failures++; $display("FAIL b1_done_cyc got=%0d exp=35", done_cyc); end
        checks++; if (ss_at_done !== 1'b0) begin failures++; $display("FAIL b1_ss_at_done got=%b exp=0", ss_at_done); end
        checks++; if (busy_at_done !== 1'b0) begin failures++; $display("FAIL b1_busy_at_done got=%b exp=0", busy_at_done); end
        checks++; if (din_at_done !== 32'h3C) begin failures++; $display("FAIL b1_data_in got=%h exp=0000003c", din_at_done); end
        data_out = 32'hC3; wrt = 1'b1;
        watch(200);
        checks++; if (done_cyc != 35) begin failures++; $display("FAIL b2_done_cyc got=%0d exp=35", done_cyc); end
        checks++; if (ss_high != 0) begin failures++; $display("FAIL b2_ss_high got=%0d exp=0", ss_high); end
        checks++; if (din_at_done !== 32'hC3) begin failures++; $display("FAIL b2_data_in got=%h exp=000000c3", din_at_done); end
        @(negedge clk);
        checks++; if (SS_n !== 1'b0) begin failures++; $display("FAIL b_hold_ss got=%b exp=0", SS_n); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b_hold_busy got=%b exp=0", busy); end
        ss_rel = 1'b1;
        @(posedge clk); #1 ss_rel = 1'b0;
        @(negedge clk);
        checks++; if (SS_n !== 1'b1) begin failures++; $display("FAIL b_release_ss got=%b exp=1", SS_n); end
        hold_ss = 1'b0;
    endtask

    task automatic test_boundaries;
        len = 5'd0; div = 8'd0; data_out = 32'h1; hold_ss = 1'b0;
        @(negedge clk); wrt = 1'b1;
        watch(100);
        checks++; if (n_edges != 2) begin failures++; $display("FAIL len0_edges got=%0d exp=2", n_edges); end
        checks++; if (done_cyc != 4) begin failures++; $display("FAIL len0_done_cyc got=%0d exp=4", done_cyc); end
        checks++; if (din_at_done !== 32'h1) begin failures++; $display("FAIL len0_data_in got=%h exp=00000001", din_at_done); end
        len = 5'd31; data_out = 32'hDEADBEEF;
        @(negedge clk); wrt = 1'b1;
        watch(200);
        checks++; if (done_cyc != 66) begin failures++; $display("FAIL len31_done_cyc got=%0d exp=66", done_cyc); end
        checks++; if (din_at_done !== 32'hDEADBEEF) begin failures++; $display("FAIL len31_data_in got=%h exp=deadbeef", din_at_done); end
        len = 5'd7; div = 8'd1; data_out = 32'hA5; again_cyc = 10;
        @(negedge clk); wrt = 1'b1;
        watch(200);
        again_cyc = -1;
        checks++; if (n_edges != 16) begin failures++; $display("FAIL busy_wrt_edges got=%0d exp=16", n_edges); end
        checks++; if (done_cyc != 35) begin failures++; $display("FAIL busy_wrt_done_cyc got=%0d exp=35", done_cyc); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_wrt_no_queue got=%b exp=0", busy); end
        hold_ss = 1'b1; data_out = 32'h5A;
        @(negedge clk); wrt = 1'b1;
        watch(200);
        data_out = 32'h66; wrt = 1'b1; ss_rel = 1'b1;
        watch(200);
        checks++; if (ss_high != 0) begin failures++; $display("FAIL wrt_rel_ss_high got=%0d exp=0", ss_high); end
        checks++; if (done_cyc != 35) begin failures++; $display("FAIL wrt_rel_done_cyc got=%0d exp=35", done_cyc); end
        checks++; if (din_at_done !== 32'h66) begin failures++; $display("FAIL wrt_rel_data_in got=%h exp=00000066", din_at_done); end
        ss_rel = 1'b1;
        @(posedge clk); #1 ss_rel = 1'b0;
        hold_ss = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int done_seen;
        len = 5'd7; div = 8'd1; data_out = 32'hA5; hold_ss = 1'b0;
        @(negedge clk); wrt = 1'b1;
        @(posedge clk); #1 wrt = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (SS_n !== 1'b1) begin failures++; $display("FAIL rmid_ss_n got=%b exp=1", SS_n); end
        checks++; if (SCLK !== 1'b0) begin failures++; $display("FAIL rmid_sclk got=%b exp=0", SCLK); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        checks++; if (done_seen != 0) begin failures++; $display("FAIL rmid_no_done got=%0d exp=0", done_seen); end
        wrt = 1'b1;
        watch(200);
        checks++; if (done_cyc != 35) begin failures++; $display("FAIL rmid_after_done_cyc got=%0d exp=35", done_cyc); end
        checks++; if (din_at_done !== 32'hA5) begin failures++; $display("FAIL rmid_after_data_in got=%h exp=000000a5", din_at_done); end
    endtask

    initial begin
        rst = 1'b1; wrt = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        hold_ss = 1'b0; ss_rel = 1'b0; data_out = '0; len = '0; div = '0;
        test_reset();
        test_mode0_msb();
        test_mode3_lsb();
        test_burst();
        test_boundaries();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
